// File: rtl/pwm_cfg_sequencer.sv
// Start/stop and configuration sequencer for the PWM up/down counter; new settings reach the counter only on a wrap.
// Optional feature: define PWM_SEQ_WRAP_IRQ_EN to get a one-cycle wrap_irq pulse per detected wrap.
module pwm_cfg_sequencer #(
    parameter int CNT_W = 16,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_upnotdown,
    input  logic [CNT_W-1:0] count_val,
    output logic             cnt_en,
    output logic             cnt_reset,
    output logic [CNT_W-1:0] cnt_period,
    output logic [PRE_W-1:0] cnt_prescale,
    output logic             cnt_upnotdown,
    output logic             busy,
    output logic             commit_pulse,
    output logic             wrap_irq
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] shd_period_q, shd_period_d;
    logic [PRE_W-1:0] shd_prescale_q, shd_prescale_d;
    logic             shd_up_q, shd_up_d;
    logic             pending_q, pending_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic [CNT_W-1:0] cnt_period_q, cnt_period_d;
    logic [PRE_W-1:0] cnt_prescale_q, cnt_prescale_d;
    logic             cnt_upnotdown_q, cnt_upnotdown_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;
    logic             commit_pulse_q, commit_pulse_d;

    logic [CNT_W-1:0] wrap_target_s;
    logic             counting_s;
    logic             wrap_s;
    logic             accept_s;

    // A wrap is the counter arriving at its start value: 0 when counting up, the period when counting down.
    assign counting_s    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign wrap_target_s = cnt_upnotdown_q ? {CNT_W{1'b0}} : cnt_period_q;
    assign wrap_s        = counting_s && (count_val != count_q) && (count_val == wrap_target_s);
    assign accept_s      = cfg_valid && cfg_ready_q;

    // Next-state, shadow/active configuration and registered output decode.
    always_comb begin
        state_d         = state_q;
        shd_period_d    = shd_period_q;
        shd_prescale_d  = shd_prescale_q;
        shd_up_d        = shd_up_q;
        pending_d       = pending_q;
        cnt_period_d    = cnt_period_q;
        cnt_prescale_d  = cnt_prescale_q;
        cnt_upnotdown_d = cnt_upnotdown_q;
        commit_pulse_d  = 1'b0;
        count_d         = (state_q == ST_LOAD) ? {CNT_W{1'b0}} : count_val;

        // Commit uses the shadow as it stood before this cycle's write, so a same-cycle write waits a wrap.
        if (wrap_s && pending_q) begin
            cnt_period_d    = shd_period_q;
            cnt_prescale_d  = shd_prescale_q;
            cnt_upnotdown_d = shd_up_q;
            pending_d       = 1'b0;
            commit_pulse_d  = 1'b1;
        end else begin
            commit_pulse_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_period_d    = cfg_period;
                    cnt_prescale_d  = cfg_prescale;
                    cnt_upnotdown_d = cfg_upnotdown;
                end else begin
                    pending_d = pending_q;
                end
                state_d = start ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept_s) begin
                    shd_period_d   = cfg_period;
                    shd_prescale_d = cfg_prescale;
                    shd_up_d       = cfg_upnotdown;
                    pending_d      = 1'b1;
                end else begin
                    shd_period_d = shd_period_q;
                end
                state_d = stop ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                state_d = wrap_s ? ST_HALT : ST_DRAIN;
            end
            ST_HALT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cnt_en_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        cnt_reset_d = (state_d == ST_LOAD) || (state_d == ST_HALT);
        busy_d      = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE: cfg_ready_d = 1'b1;
            ST_RUN:  cfg_ready_d = !pending_d;
            default: cfg_ready_d = 1'b0;
        endcase
    end

    // State, configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            count_q         <= {CNT_W{1'b0}};
            shd_period_q    <= {CNT_W{1'b0}};
            shd_prescale_q  <= {PRE_W{1'b0}};
            shd_up_q        <= 1'b0;
            pending_q       <= 1'b0;
            cnt_en_q        <= 1'b0;
            cnt_reset_q     <= 1'b0;
            cnt_period_q    <= {CNT_W{1'b0}};
            cnt_prescale_q  <= {PRE_W{1'b0}};
            cnt_upnotdown_q <= 1'b1;
            cfg_ready_q     <= 1'b0;
            busy_q          <= 1'b0;
            commit_pulse_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            shd_period_q    <= shd_period_d;
            shd_prescale_q  <= shd_prescale_d;
            shd_up_q        <= shd_up_d;
            pending_q       <= pending_d;
            cnt_en_q        <= cnt_en_d;
            cnt_reset_q     <= cnt_reset_d;
            cnt_period_q    <= cnt_period_d;
            cnt_prescale_q  <= cnt_prescale_d;
            cnt_upnotdown_q <= cnt_upnotdown_d;
            cfg_ready_q     <= cfg_ready_d;
            busy_q          <= busy_d;
            commit_pulse_q  <= commit_pulse_d;
        end
    end

    assign cnt_en        = cnt_en_q;
    assign cnt_reset     = cnt_reset_q;
    assign cnt_period    = cnt_period_q;
    assign cnt_prescale  = cnt_prescale_q;
    assign cnt_upnotdown = cnt_upnotdown_q;
    assign cfg_ready     = cfg_ready_q;
    assign busy          = busy_q;
    assign commit_pulse  = commit_pulse_q;

`ifdef PWM_SEQ_WRAP_IRQ_EN
    logic wrap_irq_q, wrap_irq_d;

    assign wrap_irq_d = wrap_s;

    // One-cycle wrap interrupt, one cycle after the wrap is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_irq_q <= 1'b0;
        end else begin
            wrap_irq_q <= wrap_irq_d;
        end
    end

    assign wrap_irq = wrap_irq_q;
`else
    assign wrap_irq = 1'b0;
`endif

endmodule
